// File: rtl/risc_controller_fsm.sv
// risc_controller_fsm: IR, decode and fetch/execute sequencer for the 16-bit datapath.
// Define BRANCH_EN to add the conditional branch (opcode 001) unit.
module risc_controller_fsm #(
  parameter logic [1:0] MEM_NONE  = 2'b00,
  parameter logic [1:0] MEM_READ  = 2'b01,
  parameter logic [1:0] MEM_WRITE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mdata,
  input  logic        Z,
  input  logic        V,
  input  logic        N,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        pc_sel,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        halt
);
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIM, S_GETA, S_GETB, S_ALU, S_WRC,
    S_ADDR, S_LADDR, S_RD1, S_RD2, S_STB, S_STC, S_WR, S_BR, S_HALT
  } state_t;
  state_t      r_state, w_next;
  logic [15:0] r_ir;
  logic [2:0]  w_opcode, w_rn, w_rd, w_rm;
  logic [1:0]  w_op, w_sh;
  logic        w_movi, w_mov, w_mvn, w_cmp, w_alu, w_ldr, w_str;
  assign {w_opcode, w_op, w_rn, w_rd, w_sh, w_rm} = r_ir;
  assign w_movi = w_opcode == 3'b110 && w_op == 2'b10;
  assign w_mov  = w_opcode == 3'b110 && w_op == 2'b00;
  assign w_alu  = w_opcode == 3'b101;
  assign w_mvn  = w_alu && w_op == 2'b11;
  assign w_cmp  = w_alu && w_op == 2'b01;
  assign w_ldr  = w_opcode == 3'b011 && w_op == 2'b00;
  assign w_str  = w_opcode == 3'b100 && w_op == 2'b00;
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
`ifdef BRANCH_EN
  logic w_taken, w_cond_ok;
  assign w_cond_ok = w_rn <= 3'd4;
  assign w_taken = (w_rn == 3'd0) || (w_rn == 3'd1 && Z) || (w_rn == 3'd2 && !Z) ||
                   (w_rn == 3'd3 && (N ^ V)) || (w_rn == 3'd4 && ((N ^ V) || Z));
`else
  logic w_unused;
  assign w_unused = ^{Z, V, N};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (load_ir) r_ir <= mdata;
    end
  end
  always_comb begin
    w_next    = r_state;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    shift     = 2'b00;
    ALUop     = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    pc_sel    = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halt      = 1'b0;
    case (r_state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        w_next   = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        w_next   = S_IF2;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
        w_next   = S_UPC;
      end
      S_UPC: begin
        load_pc = 1'b1;
        w_next  = S_DEC;
      end
      // MOVI writes here but still spends one more cycle in S_WIM (5-cycle instruction)
      S_DEC: begin
        if (w_movi) begin
          writenum = w_rn;
          vsel     = 2'b01;
          write    = 1'b1;
          w_next   = S_WIM;
        end else if (w_mov || w_mvn) w_next = S_GETB;
        else if (w_alu || w_ldr || w_str) w_next = S_GETA;
`ifdef BRANCH_EN
        else if (w_opcode == 3'b001) w_next = S_BR;
`endif
        else w_next = S_HALT;
      end
      S_WIM: w_next = S_IF1;
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = (w_ldr || w_str) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
        shift   = w_sh;
        w_next  = S_ALU;
      end
      S_ALU: begin
        asel   = w_mov || w_mvn;
        ALUop  = w_op;
        shift  = w_sh;
        loadc  = !w_cmp;
        w_next = w_cmp ? S_IF1 : S_WRC;
      end
      S_WRC: begin
        writenum = w_rd;
        vsel     = 2'b11;
        write    = 1'b1;
        w_next   = S_IF1;
      end
      S_ADDR: begin
        bsel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_LADDR;
      end
      S_LADDR: begin
        load_addr = 1'b1;
        w_next    = w_ldr ? S_RD1 : S_STB;
      end
      S_RD1: begin
        mem_cmd = MEM_READ;
        w_next  = S_RD2;
      end
      S_RD2: begin
        mem_cmd  = MEM_READ;
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_IF1;
      end
      S_STB: begin
        readnum = w_rd;
        loadb   = 1'b1;
        w_next  = S_STC;
      end
      S_STC: begin
        asel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        mem_cmd = MEM_WRITE;
        w_next  = S_IF1;
      end
      S_BR: begin
`ifdef BRANCH_EN
        load_pc = w_taken;
        pc_sel  = w_taken;
        w_next  = w_cond_ok ? S_IF1 : S_HALT;
`else
        w_next  = S_HALT;
`endif
      end
      S_HALT: halt = 1'b1;
      default: w_next = S_RST;
    endcase
  end
endmodule
